// File: rtl/wb_regfile_dual_pkg.sv
// Shared constants for the dual-lane writeback stage and its register file.
package wb_regfile_dual_pkg;

   localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
   localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
   localparam logic [1:0] MEMTOREG_LINK = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] LINK_REG = 5'd31;

   localparam int NUM_REGS = 32;

endpackage

// File: rtl/wb_lane_select.sv
// One writeback lane: picks the result source and resolves the effective
// destination and write enable. Purely combinational.
module wb_lane_select
   import wb_regfile_dual_pkg::*;
#(
   parameter int         DATA_W    = 32,
   parameter int         PC_W      = 6,
   parameter logic [4:0] LINK_ADDR = 5'd31
) (
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [DATA_W-1:0] alu_res_i,
   input  logic [PC_W-1:0]   pcplus1_i,
   input  logic [1:0]        memtoreg_i,
   input  logic [4:0]        dst_i,
   input  logic              regwrite_i,
   output logic              we_o,
   output logic [4:0]        addr_o,
   output logic [DATA_W-1:0] data_o
);

   // Source mux; the reserved encoding falls back to the ALU result.
   always_comb begin
      data_o = alu_res_i;
      addr_o = dst_i;
      case (memtoreg_i)
         MEMTOREG_MEM:  data_o = mem_data_i;
         MEMTOREG_LINK: begin
            data_o = {{(DATA_W-PC_W){1'b0}}, pcplus1_i};
            addr_o = LINK_ADDR;
         end
         default: data_o = alu_res_i;
      endcase
      we_o = regwrite_i && (addr_o != REG_ZERO);
   end

endmodule

// File: rtl/wb_regfile_dual.sv
// Dual-lane writeback with a 2-write/4-read register file.
// Define WB_BYPASS_EN to forward same-cycle writes onto the read ports.
module wb_regfile_dual #(
   parameter int         DATA_W   = 32,
   parameter int         PC_W     = 6,
   parameter logic [4:0] LINK_REG = 5'd31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wb0_mem_data,
   input  logic [DATA_W-1:0] wb1_mem_data,
   input  logic [DATA_W-1:0] wb0_alu_res,
   input  logic [DATA_W-1:0] wb1_alu_res,
   input  logic [4:0]        wb0_dst,
   input  logic [4:0]        wb1_dst,
   input  logic [1:0]        wb0_memtoreg,
   input  logic [1:0]        wb1_memtoreg,
   input  logic              wb0_regwrite,
   input  logic              wb1_regwrite,
   input  logic [PC_W-1:0]   wb0_pcplus1,
   input  logic [PC_W-1:0]   wb1_pcplus1,
   input  logic [4:0]        rd_addr0,
   input  logic [4:0]        rd_addr1,
   input  logic [4:0]        rd_addr2,
   input  logic [4:0]        rd_addr3,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [DATA_W-1:0] rd_data3,
   output logic              fwd0_we,
   output logic              fwd1_we,
   output logic [4:0]        fwd0_addr,
   output logic [4:0]        fwd1_addr,
   output logic [DATA_W-1:0] fwd0_data,
   output logic [DATA_W-1:0] fwd1_data
);
   import wb_regfile_dual_pkg::*;

   logic              we0_s, we1_s;
   logic [4:0]        addr0_s, addr1_s;
   logic [DATA_W-1:0] data0_s, data1_s;
   logic              wr0_s, wr1_s;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   wb_lane_select #(.DATA_W(DATA_W), .PC_W(PC_W), .LINK_ADDR(LINK_REG)) u_lane0 (
      .mem_data_i (wb0_mem_data),
      .alu_res_i  (wb0_alu_res),
      .pcplus1_i  (wb0_pcplus1),
      .memtoreg_i (wb0_memtoreg),
      .dst_i      (wb0_dst),
      .regwrite_i (wb0_regwrite),
      .we_o       (we0_s),
      .addr_o     (addr0_s),
      .data_o     (data0_s)
   );

   wb_lane_select #(.DATA_W(DATA_W), .PC_W(PC_W), .LINK_ADDR(LINK_REG)) u_lane1 (
      .mem_data_i (wb1_mem_data),
      .alu_res_i  (wb1_alu_res),
      .pcplus1_i  (wb1_pcplus1),
      .memtoreg_i (wb1_memtoreg),
      .dst_i      (wb1_dst),
      .regwrite_i (wb1_regwrite),
      .we_o       (we1_s),
      .addr_o     (addr1_s),
      .data_o     (data1_s)
   );

   // Forwarding buses expose the lane decisions regardless of reset.
   assign fwd0_we   = we0_s;
   assign fwd1_we   = we1_s;
   assign fwd0_addr = addr0_s;
   assign fwd1_addr = addr1_s;
   assign fwd0_data = data0_s;
   assign fwd1_data = data1_s;

   // Writes into the array (and the bypass) are suppressed while reset is held.
   assign wr0_s = we0_s && reset;
   assign wr1_s = we1_s && reset;

   // Storage; lane 1's write is scheduled last so it wins a shared destination.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (wr0_s) begin
            regs_q[addr0_s] <= data0_s;
         end
         if (wr1_s) begin
            regs_q[addr1_s] <= data1_s;
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
`ifdef WB_BYPASS_EN
      if (addr == REG_ZERO) begin
         val = '0;
      end else if (wr1_s && (addr == addr1_s)) begin
         val = data1_s;
      end else if (wr0_s && (addr == addr0_s)) begin
         val = data0_s;
      end else begin
         val = regs_q[addr];
      end
`else
      if (addr == REG_ZERO) begin
         val = '0;
      end else begin
         val = regs_q[addr];
      end
`endif
      return val;
   endfunction

   // Four combinational read ports.
   always_comb begin
      rd_data0 = read_port(rd_addr0);
      rd_data1 = read_port(rd_addr1);
      rd_data2 = read_port(rd_addr2);
      rd_data3 = read_port(rd_addr3);
   end

endmodule

// File: doc/wb_regfile_dual.md
Name: wb_regfile_dual

Overview:
- Writeback-side consumer of the two MEM/WB pipeline registers in the dual-issue core.
- Per lane, selects the write-back value from memory data, ALU result or link address, then commits it to a shared 32x32 register file.
- Register file has two write ports and four read ports: rs/rt for each decode lane.
- Exports each lane's resolved write-back bus so the EX forwarding unit can use it.

Parameters:
- DATA_W, 32, register and data width
- PC_W, 6, width of the pcPlus1 link field
- LINK_REG, 31, destination register forced for link writes

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-low reset
- wb0_mem_data / wb1_mem_data  in  DATA_W  memory read data, lane 0 / lane 1
- wb0_alu_res / wb1_alu_res  in  DATA_W  ALU result, lane 0 / lane 1
- wb0_dst / wb1_dst  in  5  destination register (rd or rt)
- wb0_memtoreg / wb1_memtoreg  in  2  write-back source select
- wb0_regwrite / wb1_regwrite  in  1  write enable
- wb0_pcplus1 / wb1_pcplus1  in  PC_W  link value
- rd_addr0..rd_addr3  in  5 each  read addresses (lane0 rs, lane0 rt, lane1 rs, lane1 rt)
- rd_data0..rd_data3  out  DATA_W each  read data
- fwd0_we / fwd1_we  out  1  effective write enable per lane
- fwd0_addr / fwd1_addr  out  5  effective destination per lane
- fwd0_data / fwd1_data  out  DATA_W  resolved write-back data per lane

Behaviour:
- Source select per lane:
  - memtoreg 00: ALU result.
  - memtoreg 01: memory read data.
  - memtoreg 10: pcplus1 zero-extended to DATA_W; destination forced to LINK_REG.
  - memtoreg 11: reserved, treated as 00.
- Effective write enable per lane = regwrite AND (effective destination != 0).
- Register 0 always reads 0 and is never written.
- Writes commit at posedge clk; the written value is visible on read ports from the next cycle (or the same cycle if WB_BYPASS_EN is defined).
- Same-destination conflict: when both lanes are enabled with an equal effective destination, lane 1 (younger) wins. Lane 0's value is dropped for that register.
- Read ports are combinational from array contents.
- fwd* outputs are purely combinational from the inputs. Zero latency.
- Reset (async, reset==0):
  - All 32 registers clear to 0 immediately.
  - rd_data reflects 0 during reset.
  - Writes asserted while reset is low are ignored.
  - fwd* outputs still follow their inputs (combinational).
- Release of reset mid-cycle: the first write takes effect at the first posedge after reset is high.
- No backpressure. Every cycle the block consumes whatever the MEM/WB registers present.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: each read port returns write data in the same cycle when its address matches an effective write this cycle. Lane 1 has priority over lane 0; address 0 always reads 0. Decode therefore sees same-cycle writeback without a stall.
- Undefined: reads return array contents only. The hazard unit must stall one extra cycle for a WB-to-decode dependency.

Decomposition:
- Shared package holds:
  - MEMTOREG_ALU=2'b00, MEMTOREG_MEM=2'b01, MEMTOREG_LINK=2'b10
  - REG_ZERO=5'd0, LINK_REG=5'd31
  - NUM_REGS=32
- One sub-module wb_lane_select, instantiated twice. Maps (mem_data, alu_res, pcplus1, memtoreg, dst, regwrite) to (we, addr, data), all combinational.
- Top level holds the storage array, the conflict priority and the optional bypass.

Test Plan:
- Reset low, then high; read all 32 addresses -> every rd_data = 0x00000000.
- Lane 0 regwrite=1, dst=5, memtoreg=01, mem_data=0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF. fwd0_we=1, fwd0_addr=5 during the write cycle.
- Lane 1 memtoreg=10, pcplus1=6'd17, dst=3 -> register 31 = 0x00000011; register 3 unchanged; fwd1_addr=31.
- Both lanes dst=9 in the same cycle, lane 0 alu_res=0x1111, lane 1 alu_res=0x2222 -> register 9 = 0x2222.
- Lane 0 regwrite=1, dst=0, alu_res=0xFFFF -> fwd0_we=0; register 0 reads 0.
- With WB_BYPASS_EN, lane 0 writes 0xABCD to reg 7 while rd_addr2=7 -> rd_data2=0xABCD in the same cycle. Without the macro -> old value that cycle, 0xABCD the next.
- Assert reset between write cycles after reg 4 = 0x55 -> rd_data for reg 4 = 0 immediately, before any clock edge.
